// File: rtl/uart_rx_sampler.sv
//==============================================================================
// Module   : uart_rx_sampler
// Purpose  : 8N1 UART receiver front end. Each bit is decided by a 3-sample
//            majority vote around its centre, and the received byte is held
//            in a valid/ready output register. Framing errors are reported as
//            a one-cycle pulse. A frame that completes while the previous byte
//            is still unconsumed sets a sticky overrun flag.
//
// Parameters
//   WAIT           clock cycles per bit (8..65535)
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   uart_rx        serial line, already synchronised, idle high
//   rx_data  [7:0] last accepted byte (LSB received first)
//   rx_valid       rx_data holds an unconsumed byte
//   rx_ready       consumer accepts rx_data when rx_valid && rx_ready
//   framing_error  one-cycle pulse when the stop bit samples low
//   overrun        sticky, a good frame was dropped while rx_valid was held
//
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_sampler #(
   parameter int WAIT = 234
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       framing_error,
   output logic       overrun
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int c_H  = WAIT / 2;
   localparam int c_CW = $clog2(WAIT);

   // The counter holds the offset within the current bit. The three vote
   // samples are taken at offsets H-1, H and H+1, and the decision is made
   // at H+1 using the two stored samples plus the live line value.
   localparam logic [c_CW-1:0] c_SMP_A = c_CW'(c_H - 1);
   localparam logic [c_CW-1:0] c_SMP_B = c_CW'(c_H);
   localparam logic [c_CW-1:0] c_DEC   = c_CW'(c_H + 1);
   localparam logic [c_CW-1:0] c_LAST  = c_CW'(WAIT - 1);
   localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

   // -------------------------------------------------------------------------
   // State machine encoding
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } t_state;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   t_state            r_state;
   logic [c_CW-1:0]   r_cnt;
   logic [2:0]        r_bit_idx;
   logic              r_armed;
   logic              r_smp_a;
   logic              r_smp_b;
   logic [7:0]        r_shift;
   logic [7:0]        r_rx_data;
   logic              r_rx_valid;
   logic              r_framing_error;
   logic              r_overrun;

   // -------------------------------------------------------------------------
   // Combinational signals
   // -------------------------------------------------------------------------
   t_state            w_state_next;
   logic [c_CW-1:0]   w_cnt_next;
   logic [2:0]        w_bit_idx_next;
   logic              w_shift_en;
   logic              w_frame_good;
   logic              w_frame_bad;
   logic              w_at_dec;
   logic              w_at_last;
   logic              w_majority;
   logic              w_handshake;
   logic              w_load;

   assign w_at_dec   = (r_cnt == c_DEC);
   assign w_at_last  = (r_cnt == c_LAST);
   assign w_majority = (r_smp_a & r_smp_b) | (r_smp_a & uart_rx) | (r_smp_b & uart_rx);

   assign w_handshake = r_rx_valid & rx_ready;
   // A good frame is taken when the output register is empty or is being
   // drained in this very cycle; otherwise the new byte is dropped.
   assign w_load      = w_frame_good & (~r_rx_valid | w_handshake);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and control decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt + c_ONE;
      w_bit_idx_next = r_bit_idx;
      w_shift_en     = 1'b0;
      w_frame_good   = 1'b0;
      w_frame_bad    = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            // The detection cycle is offset 0 of the start bit, so the
            // counter resumes at 1.
            if (r_armed && !uart_rx) begin
               w_state_next = S_START;
               w_cnt_next   = c_ONE;
            end
         end

         S_START: begin
            if (w_at_dec && w_majority) begin
               // Line recovered before the start bit centre: treat as noise.
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end else if (w_at_last) begin
               w_state_next   = S_DATA;
               w_cnt_next     = '0;
               w_bit_idx_next = 3'd0;
            end
         end

         S_DATA: begin
            if (w_at_dec) begin
               w_shift_en = 1'b1;
            end
            if (w_at_last) begin
               w_cnt_next = '0;
               if (r_bit_idx == 3'd7) begin
                  w_state_next = S_STOP;
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end
         end

         S_STOP: begin
            // Leave mid-stop-bit so a fast transmitter's next start edge
            // is not missed.
            if (w_at_dec) begin
               w_frame_good = w_majority;
               w_frame_bad  = ~w_majority;
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end
         end

         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt           <= '0;
         r_bit_idx       <= 3'd0;
         r_armed         <= 1'b0;
         r_smp_a         <= 1'b1;
         r_smp_b         <= 1'b1;
         r_shift         <= 8'h00;
         r_rx_data       <= 8'h00;
         r_rx_valid      <= 1'b0;
         r_framing_error <= 1'b0;
         r_overrun       <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_next;
         r_bit_idx <= w_bit_idx_next;

         // Stay disarmed until the line has been seen idle, so a line held
         // low through reset is never mistaken for a start bit.
         r_armed <= r_armed | uart_rx;

         if (r_cnt == c_SMP_A) begin
            r_smp_a <= uart_rx;
         end
         if (r_cnt == c_SMP_B) begin
            r_smp_b <= uart_rx;
         end

         if (w_shift_en) begin
            r_shift <= {w_majority, r_shift[7:1]};
         end

         r_framing_error <= w_frame_bad;

         if (w_load) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
         end else if (w_handshake) begin
            r_rx_valid <= 1'b0;
         end

         if (w_frame_good && r_rx_valid && !w_handshake) begin
            r_overrun <= 1'b1;
         end else if (w_handshake) begin
            r_overrun <= 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign rx_data       = r_rx_data;
   assign rx_valid      = r_rx_valid;
   assign framing_error = r_framing_error;
   assign overrun       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
//==============================================================================
// Module   : tb_uart_rx_sampler
// Purpose  : Directed self-checking bench for uart_rx_sampler with WAIT = 16.
//            Cycle k of a frame is the k-th clock period after the detection
//            cycle; line values are driven and outputs sampled on negedges.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx_sampler;

   localparam int WAIT = 16;

   logic       clk;
   logic       reset;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       framing_error;
   logic       overrun;

   int errors = 0;
   int checks = 0;

   // Event counters maintained from the outputs.
   int   fe_pulses   = 0;
   int   valid_rises = 0;
   logic prev_valid  = 1'b0;

   uart_rx_sampler #(
      .WAIT(WAIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .uart_rx      (uart_rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .framing_error(framing_error),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (framing_error === 1'b1) fe_pulses++;
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
      prev_valid = rx_valid;
   end

   // Drive one 8N1 frame. Cycle c of the frame is driven at the c-th negedge
   // after the call; 'spike' inverts the line for that single cycle (-1: none).
   task automatic send_frame(input logic [7:0] data, input logic stop, input int spike);
      logic v;
      for (int c = 0; c < 10 * WAIT; c++) begin
         int n;
         n = c / WAIT;
         if (n == 0)      v = 1'b0;
         else if (n == 9) v = stop;
         else             v = data[n-1];
         if (c == spike) v = ~v;
         @(negedge clk);
         uart_rx = v;
      end
      @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      uart_rx  = 1'b0;
      rx_ready = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      checks++;
      if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      checks++;
      if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error: got %b want 0", framing_error); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      reset = 1'b0;
      repeat (50) @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      @(posedge clk);
      checks++;
      if (rx_valid !== 1'b0 || framing_error !== 1'b0 || overrun !== 1'b0)
         begin errors++; $display("FAIL reset_low_line: valid=%b fe=%b ovr=%b want 0 0 0", rx_valid, framing_error, overrun); end
      checks++;
      if (valid_rises != 0 || fe_pulses != 0)
         begin errors++; $display("FAIL reset_no_frame: valid_rises=%0d fe_pulses=%0d want 0 0", valid_rises, fe_pulses); end
   endtask

   task automatic test_basic;
      fork
         send_frame(8'hA5, 1'b1, -1);
         begin
            repeat (154) @(negedge clk);
            checks++;
            if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_early: rx_valid=%b at cycle 153 want 0", rx_valid); end
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
               begin errors++; $display("FAIL basic_latency: valid=%b data=%h at cycle 154 want 1 a5", rx_valid, rx_data); end
         end
      join
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checks++;
         if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
            begin errors++; $display("FAIL basic_hold: valid=%b data=%h want 1 a5", rx_valid, rx_data); end
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      checks++;
      if (rx_valid !== 1'b0 || overrun !== 1'b0)
         begin errors++; $display("FAIL basic_handshake: valid=%b ovr=%b want 0 0", rx_valid, overrun); end
   endtask

   task automatic test_glitch;
      int vr0, fe0;
      @(posedge clk);
      vr0 = valid_rises;
      fe0 = fe_pulses;
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      @(posedge clk);
      checks++;
      if (valid_rises != vr0 || fe_pulses != fe0 || rx_valid !== 1'b0)
         begin errors++; $display("FAIL glitch_ignored: rises=%0d fe=%0d valid=%b want %0d %0d 0", valid_rises, fe_pulses, rx_valid, vr0, fe0); end
      fork
         send_frame(8'hC3, 1'b1, -1);
         begin
            repeat (155) @(negedge clk);
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'hC3)
               begin errors++; $display("FAIL glitch_next_frame: valid=%b data=%h want 1 c3", rx_valid, rx_data); end
         end
      join
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_framing;
      int fe0;
      @(posedge clk);
      fe0 = fe_pulses;
      fork
         send_frame(8'h3C, 1'b0, -1);
         begin
            repeat (154) @(negedge clk);
            checks++;
            if (framing_error !== 1'b0) begin errors++; $display("FAIL framing_early: fe=%b at cycle 153 want 0", framing_error); end
            @(negedge clk);
            checks++;
            if (framing_error !== 1'b1 || rx_valid !== 1'b0)
               begin errors++; $display("FAIL framing_pulse: fe=%b valid=%b at cycle 154 want 1 0", framing_error, rx_valid); end
            @(negedge clk);
            checks++;
            if (framing_error !== 1'b0) begin errors++; $display("FAIL framing_width: fe=%b at cycle 155 want 0", framing_error); end
         end
      join
      repeat (40) @(negedge clk);
      @(posedge clk);
      checks++;
      if (fe_pulses != fe0 + 1 || rx_valid !== 1'b0)
         begin errors++; $display("FAIL framing_once: pulses=%0d valid=%b want %0d 0", fe_pulses - fe0, rx_valid, 1); end
   endtask

   task automatic test_back_to_back;
      send_frame(8'h01, 1'b1, -1);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h01 || overrun !== 1'b0)
         begin errors++; $display("FAIL b2b_first: valid=%b data=%h ovr=%b want 1 01 0", rx_valid, rx_data, overrun); end
      send_frame(8'hFF, 1'b1, -1);
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h01 || overrun !== 1'b1)
         begin errors++; $display("FAIL b2b_overrun: valid=%b data=%h ovr=%b want 1 01 1", rx_valid, rx_data, overrun); end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      checks++;
      if (rx_valid !== 1'b0 || overrun !== 1'b0)
         begin errors++; $display("FAIL b2b_clear: valid=%b ovr=%b want 0 0", rx_valid, overrun); end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_spike_and_reset;
      int vr0, fe0;
      // Data bit 3 is frame bit 4; its centre offset H=8 is frame cycle 72.
      fork
         send_frame(8'h00, 1'b1, 4 * WAIT + WAIT / 2);
         begin
            repeat (155) @(negedge clk);
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'h00)
               begin errors++; $display("FAIL spike_vote: valid=%b data=%h want 1 00", rx_valid, rx_data); end
         end
      join
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      repeat (20) @(negedge clk);
      @(posedge clk);
      vr0 = valid_rises;
      fe0 = fe_pulses;
      fork
         send_frame(8'h00, 1'b1, -1);
         begin
            repeat (61) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      join
      repeat (200) @(negedge clk);
      @(posedge clk);
      checks++;
      if (valid_rises != vr0 || fe_pulses != fe0 || rx_valid !== 1'b0)
         begin errors++; $display("FAIL reset_abort: rises=%0d fe=%0d valid=%b want %0d %0d 0", valid_rises, fe_pulses, rx_valid, vr0, fe0); end
      fork
         send_frame(8'h5A, 1'b1, -1);
         begin
            repeat (155) @(negedge clk);
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'h5A)
               begin errors++; $display("FAIL after_reset_frame: valid=%b data=%h want 1 5a", rx_valid, rx_data); end
         end
      join
   endtask

   initial begin
      reset    = 1'b1;
      uart_rx  = 1'b1;
      rx_ready = 1'b0;
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_spike_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
